cfg_reg_bank: RTL and testbench
===============================

# cfg_reg_bank

Parametrised configuration register bank: the next-generation system register file, with burst read/write access through a valid/ready command channel. It adds per-register bus write protection and a sticky error flag, parameter-supplied reset defaults, and an update strobe for exported registers. It sits between the system controller and the ALU/UART/clock-divider blocks. The low `NUM_EXPORT` registers drive those blocks directly.

## Interface
- `REG_WIDTH`, 8, data width of each register.
- `ADDR_WIDTH`, 4, address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `LEN_WIDTH`, 4, width of the burst-length field; a burst is `i_Cmd_Len+1` beats.
- `NUM_EXPORT`, 4, number of low registers exported; must be between 1 and `DEPTH`.
- `RO_MASK`, 0, `DEPTH`-bit mask; bit k=1 makes register k read-only from the bus.
- `RESET_VALUES`, reg2=0x81, reg3=0x20, all other registers 0; flat `DEPTH*REG_WIDTH` vector, register k at bits `[k*REG_WIDTH +: REG_WIDTH]`.
- `i_CLK`  in  1  single clock, rising edge.
- `i_RST`  in  1  reset, **asynchronous, active-high**.
- `i_Cmd_Valid`  in  1  command present.
- `o_Cmd_Ready`  out  1  command accepted on `i_Cmd_Valid & o_Cmd_Ready`.
- `i_Cmd_Write`  in  1  1 = write burst, 0 = read burst.
- `i_Cmd_Addr`  in  ADDR_WIDTH  start address.
- `i_Cmd_Len`  in  LEN_WIDTH  beats minus 1.
- `i_WrData`  in  REG_WIDTH  write beat data.
- `i_WrData_Valid`  in  1  write beat present.
- `o_WrData_Ready`  out  1  write beat accepted on `i_WrData_Valid & o_WrData_Ready`.
- `o_RdData`  out  REG_WIDTH  read beat data.
- `o_RdData_Valid`  out  1  read beat present.
- `i_RdData_Ready`  in  1  read beat consumed on `o_RdData_Valid & i_RdData_Ready`.
- `o_Busy`  out  1  burst in progress (state is not IDLE).
- `o_Wr_Err`  out  1  sticky flag: a write to a read-only register was dropped.
- `i_Err_Clr`  in  1  clears `o_Wr_Err`.
- `o_Export`  out  NUM_EXPORT*REG_WIDTH  registers 0..NUM_EXPORT-1, register k at `[k*REG_WIDTH +: REG_WIDTH]`.
- `o_Cfg_Update`  out  1  one-cycle strobe after any exported register is written.

## Operation
- States: IDLE, WR_BURST, RD_BURST.
- **IDLE**
  - `o_Cmd_Ready`=1; all other handshake outputs are 0.
  - On command accept, latch the start address and beat counter = `i_Cmd_Len`.
  - Move to WR_BURST or RD_BURST according to `i_Cmd_Write`.
- **WR_BURST**
  - `o_WrData_Ready`=1.
  - Each accepted beat:
    - writes `i_WrData` to the current address, unless `RO_MASK` is set for it;
    - a write to a read-only register is dropped and sets `o_Wr_Err`;
    - the address then increments.
  - The beat with counter==0 returns the FSM to IDLE.
  - `i_WrData_Valid`=0 stalls the burst indefinitely.
- **RD_BURST**
  - `o_RdData` is registered and is the content of the current address at the time it loads.
  - On each accepted beat, the next word loads, or the FSM returns to IDLE after the last beat.
  - `o_RdData` and `o_RdData_Valid` hold while `i_RdData_Ready`=0.
  - Read-only registers read normally.
- Address arithmetic is modulo `DEPTH`: an increment from `DEPTH-1` wraps to 0.
- `o_Cfg_Update` pulses for each accepted, non-dropped write whose address is below `NUM_EXPORT`. It pulses even if the value is unchanged.
- `o_Wr_Err`:
  - it is sticky;
  - `i_Err_Clr` clears it;
  - if a set and `i_Err_Clr` occur in the same cycle, the set wins.
- Commands presented while not in IDLE are ignored (`o_Cmd_Ready`=0); no queueing.
- A write burst always covers all `Len+1` beats; there is no abort except reset.

## Timing
- **Reset values:**
  - every register = its `RESET_VALUES` slice; state = IDLE;
  - `o_Cmd_Ready`=1;
  - `o_RdData`=0, `o_RdData_Valid`=0, `o_WrData_Ready`=0;
  - `o_Busy`=0, `o_Wr_Err`=0, `o_Cfg_Update`=0;
  - `o_Export` = defaults.
- Reset asserted mid-burst aborts immediately. State goes to IDLE, registers go to defaults, and partially written data is lost.
- **Write burst:**
  - command accepted at edge N; `o_WrData_Ready`=1 from cycle N+1;
  - a beat accepted at edge M is visible on `o_Export` after edge M;
  - `o_Cfg_Update` is high in the cycle after M;
  - the last beat at edge M returns to IDLE: `o_Cmd_Ready`=1 in cycle M+1.
- **Read burst:**
  - command accepted at edge N; first `o_RdData_Valid` in cycle N+1;
  - with `i_RdData_Ready` held high, one beat per cycle;
  - after the last accept at edge M, `o_RdData_Valid`=0 and `o_Cmd_Ready`=1 in cycle M+1.
- Best-case throughput is one beat per cycle in both directions.
- `o_Busy` = not IDLE, registered.

## Structure
- Package `cfg_reg_pkg` holds:
  - the state enum (IDLE/WR_BURST/RD_BURST);
  - the default `RESET_VALUES` constant;
  - a helper function for the register index slice.
- Sub-module `reg_burst_ctrl` holds the FSM, the address counter, the beat counter and the handshake outputs.
- It produces write-enable, address and read-load strobes.
- The top level holds the storage array, the RO check, the error flag, the update strobe and the export mapping.

## Test plan
- **Reset defaults:** assert `i_RST` asynchronously mid-cycle → `o_Export` reg2=0x81, reg3=0x20, all others 0; `o_Cmd_Ready`=1; all other outputs 0.
- **Write then read with wrap:**
  - write burst at addr 14, Len=3, data A1,A2,A3,A4 → regs 14,15,0,1 are written;
  - `o_Cfg_Update` pulses twice (regs 0 and 1);
  - read burst at addr 14, Len=3 → A1,A2,A3,A4 returned on consecutive cycles.
- **Read backpressure:**
  - read Len=1 at addr 2 with `i_RdData_Ready` low for 3 cycles → 0x81 held stable on `o_RdData` with valid for 3 cycles, then reg3 = 0x20;
  - `o_Cmd_Ready` returns 1 cycle after the final accept.
- **Read-only protection:**
  - `RO_MASK`=0x0008; write 0x55 to addr 3 → reg3 stays 0x20, `o_Wr_Err`=1, no `o_Cfg_Update`;
  - `i_Err_Clr` together with a second dropped write → `o_Wr_Err` stays 1;
  - `i_Err_Clr` alone → `o_Wr_Err`=0.
- **Command during a burst:** `i_Cmd_Valid` held during a write burst stalled by `i_WrData_Valid`=0 → no accept, `o_Busy`=1; the command is accepted in the cycle after the last beat.
- **Reset mid-burst:** assert `i_RST` after 2 of 4 write beats → registers return to defaults, state IDLE, no stale `o_RdData_Valid`.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared definitions for the configuration register bank: burst FSM states,
// the default power-up register image and the register slice helper.
package cfg_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } burst_state_e;

  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_DEPTH     = 16;

  // reg2 = 0x81, reg3 = 0x20, everything else 0
  localparam logic [DEF_DEPTH*DEF_REG_WIDTH-1:0] DEFAULT_RESET_VALUES =
    128'h0000_0000_0000_0000_0000_0000_2081_0000;

  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_burst_ctrl.sv
// Burst sequencer: accepts a command, walks the address/beat counters and
// emits write-enable and read-load strobes for the storage array.
module reg_burst_ctrl
  import cfg_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wr_valid_i,
  input  logic                  rd_ready_i,
  output logic                  cmd_ready_o,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  rd_load_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  logic is_idle, is_wr, is_rd;
  logic cmd_fire, wr_fire, rd_fire, last_beat;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_wr     = (state_q == ST_WR_BURST);
  assign is_rd     = (state_q == ST_RD_BURST);
  assign cmd_fire  = is_idle & cmd_valid_i;
  assign wr_fire   = is_wr & wr_valid_i;
  assign rd_fire   = is_rd & rd_ready_i;
  assign last_beat = (cnt_q == '0);
  assign addr_inc  = addr_q + ADDR_WIDTH'(1);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_addr_i;
          cnt_d   = cmd_len_i;
          state_d = cmd_write_i ? ST_WR_BURST : ST_RD_BURST;
        end
      end
      ST_WR_BURST, ST_RD_BURST: begin
        if (wr_fire || rd_fire) begin
          addr_d = addr_inc;
          if (last_beat) state_d = ST_IDLE;
          else           cnt_d   = cnt_q - LEN_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready_o = is_idle;
  assign wr_ready_o  = is_wr;
  assign rd_valid_o  = is_rd;
  assign busy_o      = ~is_idle;
  assign wr_en_o     = wr_fire;
  assign wr_addr_o   = addr_q;

  // First word loads with the command; later words load on each non-final accept
  assign rd_load_o = (cmd_fire & ~cmd_write_i) | (rd_fire & ~last_beat);
  assign rd_addr_o = is_idle ? cmd_addr_i : addr_inc;

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank: storage, read-only protection, sticky write
// error, export update strobe and the exported register bus.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int NUM_EXPORT = 4,
  parameter logic [(2**ADDR_WIDTH)-1:0]           RO_MASK      = '0,
  parameter logic [(2**ADDR_WIDTH)*REG_WIDTH-1:0] RESET_VALUES = DEFAULT_RESET_VALUES
) (
  input  logic                           i_CLK,
  input  logic                           i_RST,
  input  logic                           i_Cmd_Valid,
  output logic                           o_Cmd_Ready,
  input  logic                           i_Cmd_Write,
  input  logic [ADDR_WIDTH-1:0]          i_Cmd_Addr,
  input  logic [LEN_WIDTH-1:0]           i_Cmd_Len,
  input  logic [REG_WIDTH-1:0]           i_WrData,
  input  logic                           i_WrData_Valid,
  output logic                           o_WrData_Ready,
  output logic [REG_WIDTH-1:0]           o_RdData,
  output logic                           o_RdData_Valid,
  input  logic                           i_RdData_Ready,
  output logic                           o_Busy,
  output logic                           o_Wr_Err,
  input  logic                           i_Err_Clr,
  output logic [NUM_EXPORT*REG_WIDTH-1:0] o_Export,
  output logic                           o_Cfg_Update
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  wr_en, rd_load;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  reg_burst_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_ctrl (
    .clk_i       (i_CLK),
    .rst_i       (i_RST),
    .cmd_valid_i (i_Cmd_Valid),
    .cmd_write_i (i_Cmd_Write),
    .cmd_addr_i  (i_Cmd_Addr),
    .cmd_len_i   (i_Cmd_Len),
    .wr_valid_i  (i_WrData_Valid),
    .rd_ready_i  (i_RdData_Ready),
    .cmd_ready_o (o_Cmd_Ready),
    .wr_ready_o  (o_WrData_Ready),
    .rd_valid_o  (o_RdData_Valid),
    .busy_o      (o_Busy),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .rd_load_o   (rd_load),
    .rd_addr_o   (rd_addr)
  );

  logic [REG_WIDTH-1:0] regs_q [DEPTH];
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 err_q, err_d;
  logic                 update_q, update_d;
  logic                 ro_hit, wr_commit, wr_drop;

  assign ro_hit    = RO_MASK[wr_addr];
  assign wr_commit = wr_en & ~ro_hit;
  assign wr_drop   = wr_en & ro_hit;

  // NOTE: the array is reset because each register needs a defined power-up
  // value; this is a bank of flops, not an inferred RAM.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int k = 0; k < DEPTH; k++)
        regs_q[k] <= RESET_VALUES[reg_lsb(k, REG_WIDTH) +: REG_WIDTH];
    end else if (wr_commit) begin
      regs_q[wr_addr] <= i_WrData;
    end
  end

  always_comb begin
    rd_data_d = rd_load ? regs_q[rd_addr] : rd_data_q;
    err_d     = err_q;
    if (i_Err_Clr) err_d = 1'b0;
    // A dropped write in the same cycle as a clear leaves the flag set
    if (wr_drop)   err_d = 1'b1;
    update_d  = wr_commit && (int'(wr_addr) < NUM_EXPORT);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rd_data_q <= '0;
      err_q     <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      update_q  <= update_d;
    end
  end

  assign o_RdData     = rd_data_q;
  assign o_Wr_Err     = err_q;
  assign o_Cfg_Update = update_q;

  for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
    assign o_Export[reg_lsb(g, REG_WIDTH) +: REG_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: directed scenarios plus randomized
// bursts compared against an array-based model of the register bank.
module tb_cfg_reg_bank;

  localparam int RW = 8;
  localparam int AW = 4;
  localparam int LW = 4;
  localparam int NE = 4;
  localparam int DEPTH = 16;
  localparam logic [DEPTH-1:0] RO = 16'h0008;

  logic          i_CLK, i_RST;
  logic          i_Cmd_Valid, o_Cmd_Ready, i_Cmd_Write;
  logic [AW-1:0] i_Cmd_Addr;
  logic [LW-1:0] i_Cmd_Len;
  logic [RW-1:0] i_WrData;
  logic          i_WrData_Valid, o_WrData_Ready;
  logic [RW-1:0] o_RdData;
  logic          o_RdData_Valid, i_RdData_Ready;
  logic          o_Busy, o_Wr_Err, i_Err_Clr, o_Cfg_Update;
  logic [NE*RW-1:0] o_Export;

  cfg_reg_bank #(
    .REG_WIDTH  (RW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .NUM_EXPORT (NE),
    .RO_MASK    (RO)
  ) dut (
    .i_CLK          (i_CLK),
    .i_RST          (i_RST),
    .i_Cmd_Valid    (i_Cmd_Valid),
    .o_Cmd_Ready    (o_Cmd_Ready),
    .i_Cmd_Write    (i_Cmd_Write),
    .i_Cmd_Addr     (i_Cmd_Addr),
    .i_Cmd_Len      (i_Cmd_Len),
    .i_WrData       (i_WrData),
    .i_WrData_Valid (i_WrData_Valid),
    .o_WrData_Ready (o_WrData_Ready),
    .o_RdData       (o_RdData),
    .o_RdData_Valid (o_RdData_Valid),
    .i_RdData_Ready (i_RdData_Ready),
    .o_Busy         (o_Busy),
    .o_Wr_Err       (o_Wr_Err),
    .i_Err_Clr      (i_Err_Clr),
    .o_Export       (o_Export),
    .o_Cfg_Update   (o_Cfg_Update)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] model_mem [DEPTH];
  logic          model_err;
  logic [RW-1:0] wdata [DEPTH];
  int            clr_mode;   // 0 never, 1 every beat, 2 random beats

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_mem[2] = 8'h81;
    model_mem[3] = 8'h20;
    model_err = 1'b0;
  endtask

  function automatic logic [NE*RW-1:0] model_export();
    return {model_mem[3], model_mem[2], model_mem[1], model_mem[0]};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, o_Cmd_Ready, 1);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_wr_ready"}, o_WrData_Ready, 0);
    check({tag, "_rd_valid"}, o_RdData_Valid, 0);
  endtask

  // Presents a command and returns at the falling edge after it is accepted
  task automatic do_cmd(input logic wr, input int a, input int l);
    int waited = 0;
    i_Cmd_Valid = 1'b1;
    i_Cmd_Write = wr;
    i_Cmd_Addr  = AW'(a);
    i_Cmd_Len   = LW'(l);
    while (!o_Cmd_Ready && waited < 100) begin
      @(negedge i_CLK);
      waited++;
    end
    check("cmd_wait_bound", waited < 100, 1);
    @(negedge i_CLK);
    i_Cmd_Valid = 1'b0;
  endtask

  task automatic wr_burst(input int a, input int l, input int stall);
    do_cmd(1'b1, a, l);
    for (int i = 0; i <= l; i++) begin
      int n_st = (stall >= 0) ? stall : int'($urandom_range(0, 2));
      int addr = (a + i) % DEPTH;
      logic clr;
      logic exp_upd;
      repeat (n_st) begin
        check("wr_stall_busy", o_Busy, 1);
        @(negedge i_CLK);
        check("wr_stall_update", o_Cfg_Update, 0);
      end
      check("wr_ready", o_WrData_Ready, 1);
      clr = (clr_mode == 1) || (clr_mode == 2 && $urandom_range(0, 3) == 0);
      i_WrData       = wdata[i];
      i_WrData_Valid = 1'b1;
      i_Err_Clr      = clr;
      if (RO[addr]) begin
        model_err = 1'b1;
        exp_upd   = 1'b0;
      end else begin
        model_mem[addr] = wdata[i];
        if (clr) model_err = 1'b0;
        exp_upd = (addr < NE);
      end
      @(negedge i_CLK);
      i_WrData_Valid = 1'b0;
      i_Err_Clr      = 1'b0;
      check("wr_update", o_Cfg_Update, exp_upd);
      check("wr_export", o_Export, model_export());
      check("wr_err", o_Wr_Err, model_err);
    end
    check_idle("wr_end");
    @(negedge i_CLK);
    check("wr_update_single", o_Cfg_Update, 0);
  endtask

  task automatic rd_burst(input int a, input int l, input int stall);
    do_cmd(1'b0, a, l);
    for (int i = 0; i <= l; i++) begin
      int n_st = (stall >= 0) ? stall : int'($urandom_range(0, 2));
      logic [RW-1:0] exp = model_mem[(a + i) % DEPTH];
      repeat (n_st) begin
        check("rd_hold_valid", o_RdData_Valid, 1);
        check("rd_hold_data", o_RdData, exp);
        @(negedge i_CLK);
      end
      check("rd_valid", o_RdData_Valid, 1);
      check("rd_data", o_RdData, exp);
      i_RdData_Ready = 1'b1;
      @(negedge i_CLK);
      i_RdData_Ready = 1'b0;
    end
    check("rd_end_valid", o_RdData_Valid, 0);
    check("rd_end_cmd_ready", o_Cmd_Ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle(tag);
    check({tag, "_export"}, o_Export, 32'h2081_0000);
    check({tag, "_rd_data"}, o_RdData, 0);
    check({tag, "_err"}, o_Wr_Err, 0);
    check({tag, "_update"}, o_Cfg_Update, 0);
  endtask

  initial begin
    i_RST = 1'b1;
    i_Cmd_Valid = 1'b0; i_Cmd_Write = 1'b0; i_Cmd_Addr = '0; i_Cmd_Len = '0;
    i_WrData = '0; i_WrData_Valid = 1'b0; i_RdData_Ready = 1'b0; i_Err_Clr = 1'b0;
    clr_mode = 0;
    model_reset();
    @(negedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    check_reset_outputs("por");

    // Write/read across the top-of-array wrap
    wdata[0] = 8'hA1; wdata[1] = 8'hA2; wdata[2] = 8'hA3; wdata[3] = 8'hA4;
    wr_burst(14, 3, 0);
    rd_burst(14, 3, 0);

    // Asynchronous reset applied between clock edges
    #2 i_RST = 1'b1;
    #1 model_reset();
    check_reset_outputs("async_rst");
    @(negedge i_CLK);
    i_RST = 1'b0;

    // Read backpressure on reg2/reg3
    rd_burst(2, 1, 3);

    // Read-only register 3
    wdata[0] = 8'h55;
    wr_burst(3, 0, 0);
    clr_mode = 1;
    wr_burst(3, 0, 0);
    clr_mode = 0;
    i_Err_Clr = 1'b1;
    @(negedge i_CLK);
    i_Err_Clr = 1'b0;
    model_err = 1'b0;
    check("err_clear", o_Wr_Err, 0);

    // Command held during a stalled write burst
    do_cmd(1'b1, 5, 1);
    i_Cmd_Valid = 1'b1; i_Cmd_Write = 1'b0; i_Cmd_Addr = 4'd5; i_Cmd_Len = '0;
    repeat (3) begin
      check("hold_cmd_ready", o_Cmd_Ready, 0);
      check("hold_busy", o_Busy, 1);
      @(negedge i_CLK);
    end
    i_WrData = 8'h3C; i_WrData_Valid = 1'b1;
    @(negedge i_CLK);
    model_mem[5] = 8'h3C;
    check("hold_mid_cmd_ready", o_Cmd_Ready, 0);
    i_WrData = 8'h4D;
    @(negedge i_CLK);
    i_WrData_Valid = 1'b0;
    model_mem[6] = 8'h4D;
    check("hold_after_last_cmd_ready", o_Cmd_Ready, 1);
    @(negedge i_CLK);
    i_Cmd_Valid = 1'b0;
    check("hold_rd_valid", o_RdData_Valid, 1);
    check("hold_rd_data", o_RdData, 8'h3C);
    i_RdData_Ready = 1'b1;
    @(negedge i_CLK);
    i_RdData_Ready = 1'b0;
    check_idle("hold_done");

    // Reset in the middle of a write burst
    do_cmd(1'b1, 0, 3);
    i_WrData = 8'hEE; i_WrData_Valid = 1'b1;
    @(negedge i_CLK);
    i_WrData = 8'hDD;
    @(negedge i_CLK);
    i_WrData_Valid = 1'b0;
    check("midrst_pre_export", o_Export[15:0], 16'hDDEE);
    #2 i_RST = 1'b1;
    #1 model_reset();
    check_reset_outputs("midrst");
    @(negedge i_CLK);
    i_RST = 1'b0;
    check_idle("midrst_release");
    rd_burst(0, 15, 0);

    // Randomized traffic
    clr_mode = 2;
    repeat (40) begin
      int a = int'($urandom_range(0, DEPTH - 1));
      int l = int'($urandom_range(0, 15));
      for (int i = 0; i < DEPTH; i++) wdata[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) wr_burst(a, l, -1);
      else                           rd_burst(a, l, -1);
    end
    clr_mode = 0;
    rd_burst(0, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
